// File: rtl/ptr_sync_gray_pkg.sv
// Shared helpers and limits for the Gray pointer synchronizer.
// The helpers take 32-bit arguments; callers zero-extend and slice the result.
package ptr_sync_pkg;

   localparam int STAGES_MIN = 2;
   localparam int STAGES_MAX = 4;

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/ptr_sync_gray_if.sv
// Pointer/status bundle between the read-side FIFO logic and the synchronizer.
interface ptr_sync_gray_if #(parameter int PTR_WIDTH = 8);
   logic [PTR_WIDTH:0] wptr_gray;
   logic [PTR_WIDTH:0] rptr_bin;
   logic               err_clr;
   logic [PTR_WIDTH:0] wptr_sync_gray;
   logic [PTR_WIDTH:0] wptr_sync_bin;
   logic [PTR_WIDTH:0] level;
   logic               empty;
   logic               advance;
   logic               gray_err;

   modport master (output wptr_gray, rptr_bin, err_clr,
                   input  wptr_sync_gray, wptr_sync_bin, level, empty, advance, gray_err);
   modport slave  (input  wptr_gray, rptr_bin, err_clr,
                   output wptr_sync_gray, wptr_sync_bin, level, empty, advance, gray_err);
endinterface

// File: rtl/ptr_sync_gray_sync_chain.sv
// Generic synchronous-reset flop chain; also usable for rptr into the write domain.
module sync_chain #(
   parameter int WIDTH  = 9,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] s_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q <= '0;
      end else begin
         s_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1];
      end
   end

   assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Read-domain write-pointer synchronizer: Gray chain, binary convert, level/empty/advance.
// Optional Gray-step checker enabled by GRAY_STEP_CHECK_EN.
module ptr_sync_gray
   import ptr_sync_pkg::*;
#(
   parameter int PTR_WIDTH = 8,
   parameter int STAGES    = 2
) (
   input  logic           rdclk,
   input  logic           rd_rst_n,
   ptr_sync_gray_if.slave bus
);

   localparam int PW = PTR_WIDTH + 1;

   generate
      if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || PTR_WIDTH < 1 || PTR_WIDTH > 31) begin : g_bad_cfg
         $error("ptr_sync_gray: STAGES must be 2..4 and PTR_WIDTH 1..31");
      end
   endgenerate

   logic [PW-1:0] sync_gray;
   logic [PW-1:0] bin_d, bin_q;
   logic          adv_q;

   sync_chain #(.WIDTH(PW), .STAGES(STAGES)) u_chain (
      .clk   (rdclk),
      .rst_n (rd_rst_n),
      .d_i   (bus.wptr_gray),
      .q_o   (sync_gray)
   );

   assign bin_d = PW'(gray2bin(32'(sync_gray)));

   always_ff @(posedge rdclk) begin
      if (!rd_rst_n) begin
         bin_q <= '0;
         adv_q <= 1'b0;
      end else begin
         bin_q <= bin_d;
         adv_q <= (bin_d != bin_q);
      end
   end

   assign bus.wptr_sync_gray = sync_gray;
   assign bus.wptr_sync_bin  = bin_q;
   assign bus.advance        = adv_q;
   assign bus.level          = bin_q - bus.rptr_bin;
   assign bus.empty          = (bus.level == '0);

`ifdef GRAY_STEP_CHECK_EN
   localparam logic [2:0] WARM = 3'(STAGES + 1);

   logic [PW-1:0] gray_prev_q;
   logic [2:0]    warm_q;
   logic          err_q;
   logic          armed, bad_step;

   // Disarmed until the chain has flushed the reset zeros, masking the 0 -> live jump.
   assign armed    = (warm_q == WARM);
   assign bad_step = popcount(32'(sync_gray ^ gray_prev_q)) > 6'd1;

   always_ff @(posedge rdclk) begin
      if (!rd_rst_n) begin
         gray_prev_q <= '0;
         warm_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         gray_prev_q <= sync_gray;
         if (!armed) warm_q <= warm_q + 3'd1;
         if (bus.err_clr) err_q <= 1'b0;
         if (armed && bad_step) err_q <= 1'b1;
      end
   end

   assign bus.gray_err = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.gray_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Self-checking bench for ptr_sync_gray: directed steps plus random pointer traffic
// checked every cycle against a sample-history reference model.
module tb_ptr_sync_gray;

   localparam int PTR_WIDTH = 8;
   localparam int STAGES    = 3;
   localparam int DEP       = STAGES + 2;

   logic rdclk = 1'b0;
   logic rd_rst_n;
   always #5 rdclk = ~rdclk;

   ptr_sync_gray_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

   ptr_sync_gray #(.PTR_WIDTH(PTR_WIDTH), .STAGES(STAGES)) dut (
      .rdclk    (rdclk),
      .rd_rst_n (rd_rst_n),
      .bus      (bus)
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [8:0] g2b(input logic [8:0] g);
      logic [8:0] b;
      b = g;
      for (int s = 1; s < 9; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic logic [8:0] b2g(input logic [8:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reference: h[k] is the input sampled k edges ago (zeros after reset).
   logic [8:0] h [DEP];
   int         since_rel;
   logic       err_m;

   always @(posedge rdclk) begin
      if (!rd_rst_n) begin
         for (int i = 0; i < DEP; i++) h[i] = '0;
         since_rel = 0;
         err_m     = 1'b0;
      end else begin
         since_rel++;
         for (int i = DEP - 1; i > 0; i--) h[i] = h[i-1];
         h[0] = bus.wptr_gray;
         if (bus.err_clr) err_m = 1'b0;
         if (since_rel >= STAGES + 2 && $countones(h[STAGES] ^ h[STAGES+1]) > 1) err_m = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_gerr();
`ifdef GRAY_STEP_CHECK_EN
      return err_m;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_level();
      logic [8:0] sb;
      sb = g2b(h[STAGES]);
      chk("level", 32'(bus.level), 32'(9'(sb - bus.rptr_bin)));
      chk("empty", 32'(bus.empty), 32'(sb == bus.rptr_bin));
   endtask

   task automatic cyc();
      @(posedge rdclk);
      #1;
      chk("sync_gray", 32'(bus.wptr_sync_gray), 32'(h[STAGES-1]));
      chk("sync_bin", 32'(bus.wptr_sync_bin), 32'(g2b(h[STAGES])));
      chk("advance", 32'(bus.advance), 32'(g2b(h[STAGES]) != g2b(h[STAGES+1])));
      chk("gray_err", 32'(bus.gray_err), 32'(exp_gerr()));
      check_level();
   endtask

   task automatic reset_to(input logic [8:0] g, input int hold);
      rd_rst_n      = 1'b0;
      bus.wptr_gray = g;
      repeat (2) cyc();
      rd_rst_n = 1'b1;
      repeat (hold) cyc();
   endtask

   int n, adv_cnt, first_adv, last_adv;

   initial begin
      rd_rst_n      = 1'b0;
      bus.wptr_gray = 9'h1FF;
      bus.rptr_bin  = '0;
      bus.err_clr   = 1'b0;

      // Reset holds everything at zero despite a live input
      repeat (3) cyc();
      chk("rst_sync_gray", 32'(bus.wptr_sync_gray), 0);
      chk("rst_sync_bin", 32'(bus.wptr_sync_bin), 0);
      chk("rst_advance", 32'(bus.advance), 0);
      chk("rst_gray_err", 32'(bus.gray_err), 0);
      rd_rst_n = 1'b1;
      n = 0;
      do begin cyc(); n++; end while (!bus.advance && n < 12);
      chk("rst_first_adv", n, STAGES + 1);

      // Latency 0 -> 1
      reset_to(9'h000, 8);
      bus.wptr_gray = b2g(9'd1);
      n = 0;
      do begin cyc(); n++; end while (bus.wptr_sync_gray != 9'd1 && n < 12);
      chk("lat_gray_edges", n, STAGES);
      chk("lat_adv_early", 32'(bus.advance), 0);
      cyc();
      chk("lat_bin", 32'(bus.wptr_sync_bin), 1);
      chk("lat_level", 32'(bus.level), 1);
      chk("lat_empty", 32'(bus.empty), 0);
      chk("lat_adv", 32'(bus.advance), 1);

      // Back-to-back increments
      reset_to(9'h000, 8);
      adv_cnt = 0; first_adv = -1; last_adv = -1;
      for (int k = 1; k <= 30; k++) begin
         if (k <= 20) bus.wptr_gray = b2g(9'(k));
         cyc();
         if (bus.advance) begin
            adv_cnt++;
            if (first_adv < 0) first_adv = k;
            last_adv = k;
         end
      end
      chk("b2b_adv_count", adv_cnt, 20);
      chk("b2b_adv_span", last_adv - first_adv + 1, 20);
      chk("b2b_final_bin", 32'(bus.wptr_sync_bin), 20);

      // Illegal Gray jump after warm-up, then clear
      reset_to(9'h000, 8);
      bus.wptr_gray = 9'h003;
      repeat (STAGES + 2) cyc();
`ifdef GRAY_STEP_CHECK_EN
      chk("gerr_set", 32'(bus.gray_err), 1);
`else
      chk("gerr_off", 32'(bus.gray_err), 0);
`endif
      bus.err_clr = 1'b1;
      cyc();
      bus.err_clr = 1'b0;
      cyc();
      chk("gerr_clr", 32'(bus.gray_err), 0);

      // Same jump straight out of reset is masked
      reset_to(9'h003, 8);
      chk("gerr_warmup", 32'(bus.gray_err), 0);

      // Full and wrap
      reset_to(9'h000, 4);
      bus.wptr_gray = b2g(9'd256);
      bus.rptr_bin  = 9'd0;
      repeat (STAGES + 2) cyc();
      chk("full_level", 32'(bus.level), 256);
      chk("full_empty", 32'(bus.empty), 0);
      bus.wptr_gray = b2g(9'd511);
      repeat (STAGES + 2) cyc();
      bus.wptr_gray = b2g(9'd0);
      bus.rptr_bin  = 9'd256;
      repeat (STAGES + 2) cyc();
      chk("wrap_level", 32'(bus.level), 256);

      // Reset in the middle of a moving pipeline
      for (int k = 1; k <= 6; k++) begin
         bus.wptr_gray = b2g(9'(k));
         cyc();
      end
      rd_rst_n = 1'b0;
      cyc();
      chk("mid_rst_gray", 32'(bus.wptr_sync_gray), 0);
      chk("mid_rst_bin", 32'(bus.wptr_sync_bin), 0);
      chk("mid_rst_adv", 32'(bus.advance), 0);
      chk("mid_rst_gerr", 32'(bus.gray_err), 0);
      rd_rst_n     = 1'b1;
      bus.rptr_bin = 9'd0;

      // Random traffic with zero-latency rptr probes
      begin
         logic [8:0] wb;
         wb = 9'd0;
         bus.wptr_gray = 9'd0;
         repeat (6) cyc();
         for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) wb = 9'($urandom);
            else wb = wb + 9'($urandom_range(0, 1));
            bus.wptr_gray = b2g(wb);
            bus.rptr_bin  = 9'($urandom);
            bus.err_clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
               #1;
               check_level();
            end
            cyc();
         end
         bus.err_clr = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ptr_sync_gray.md
# ptr_sync_gray

Parametrised destination-domain pointer synchronizer for the async FIFO: carries the write-side Gray pointer into the read clock domain through a configurable-depth flop chain. It converts the synchronized pointer to binary and produces FIFO level, empty and advance indications against the local read pointer. An optional checker flags synchronized samples that violate the single-bit Gray step. It replaces the fixed two-stage pointer synchronizer on the read side and is sized for any FIFO depth.

## Interface
- PTR_WIDTH, 8, address bits; pointers are PTR_WIDTH+1 bits (extra wrap bit)
- STAGES, 2, synchronizer depth; legal range 2..4; elaboration error otherwise
- rdclk  in  1  destination (read) clock; the only clock
- rd_rst_n  in  1  synchronous, active-low reset, sampled on rising rdclk
- wptr_gray  in  PTR_WIDTH+1  write pointer, Gray-coded, asynchronous to rdclk
- rptr_bin  in  PTR_WIDTH+1  local read pointer, binary, rdclk domain
- err_clr  in  1  clears sticky gray_err
- wptr_sync_gray  out  PTR_WIDTH+1  last synchronizer stage
- wptr_sync_bin  out  PTR_WIDTH+1  registered Gray-to-binary of wptr_sync_gray
- level  out  PTR_WIDTH+1  wptr_sync_bin − rptr_bin, modulo 2^(PTR_WIDTH+1)
- empty  out  1  level == 0
- advance  out  1  one-cycle pulse when wptr_sync_bin takes a new value
- gray_err  out  1  sticky Gray-step violation flag

## Operation
- Chain s[0..STAGES-1]: s[0] <= wptr_gray, s[i] <= s[i-1]; wptr_sync_gray = s[STAGES-1].
- wptr_sync_bin <= gray2bin(s[STAGES-1]) every cycle.
- advance <= (gray2bin(s[STAGES-1]) != wptr_sync_bin); high exactly in the cycle wptr_sync_bin shows the new value.
- level, empty: combinational from wptr_sync_bin and rptr_bin; modulo subtraction, wrap bit included, so full FIFO reads level = 2^PTR_WIDTH.
- level > 2^PTR_WIDTH is not corrected; it indicates upstream pointer corruption.
- Reset (rd_rst_n=0 at an edge): all chain stages, wptr_sync_bin, advance, gray_err, warm-up counter -> 0. Applies mid-operation; no advance pulse is generated by the reset itself.
- Simultaneous update: pointer changes at the input during the cycle a previous change emerges are pipelined independently; no sample dropped inside the chain.

## Timing
- wptr_gray stable before rdclk edge k -> wptr_sync_gray at edge k+STAGES-1 output (STAGES edges of latency).
- wptr_sync_bin, advance, level, empty: STAGES+1 edges after input sample.
- rptr_bin change reflects in level/empty in the same cycle (zero latency).
- gray_err set: one edge after the offending sample reaches wptr_sync_gray.

## Configuration
- GRAY_STEP_CHECK_EN defined: gray_prev register (previous wptr_sync_gray), popcount check, and warm-up counter included. Each cycle, if armed and popcount(wptr_sync_gray ^ gray_prev) > 1, gray_err <= 1. Zero-bit or one-bit steps are legal. err_clr clears gray_err. Set wins over err_clr in the same cycle. Warm-up counter counts STAGES+1 cycles after reset release; check disarmed until it saturates, masking the 0 -> live-pointer jump.
- Not defined: gray_err tied 0, err_clr ignored, no gray_prev or counter logic.

## Structure
- Package ptr_sync_pkg: functions gray2bin, bin2gray, popcount; constants STAGES_MIN=2, STAGES_MAX=4.
- Sub-module sync_chain #(WIDTH, STAGES): generic synchronous-reset flop chain; instantiated once. Reused for rptr into write domain.

## Test plan
- Reset: drive wptr_gray=9'h1FF with rd_rst_n=0 for 3 cycles -> all outputs 0, no advance. Release -> first advance STAGES+1 edges later.
- Latency: STAGES=3, step wptr_gray 0 -> 1 (bin 1), rptr_bin=0 -> wptr_sync_gray=1 after 3 edges. wptr_sync_bin=1, level=1, empty=0, advance one cycle after 4 edges.
- Wrap/full: PTR_WIDTH=3, wptr bin 8 (gray 0xC), rptr_bin=0 -> level=8. Then wptr bin 15 -> 0 wrap, rptr_bin=8 -> level 8 -> 8, no underflow.
- Back-to-back: increment wptr_gray Gray sequence every cycle for 20 cycles -> advance high 20 consecutive cycles, final wptr_sync_bin=20.
- Gray check (macro on): after warm-up, jump wptr_gray 0 -> 3 -> gray_err=1 at STAGES+1 edges. err_clr pulse -> 0. Jump during warm-up -> no error.
- Reset mid-stream: assert rd_rst_n=0 while pipeline holds changing values -> next edge all 0, gray_err cleared. Macro off: gray_err stays 0 under the 0 -> 3 jump.
